// File: rtl/ias_memory_responder.sv
// Memory-side responder for the IAS datapath: accepts one read/write request at a
// time, accesses an internal word array after LATENCY cycles and returns the result.
module ias_memory_responder #(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 8,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_we,
    output logic              busy
);

    localparam int DEPTH = 2 ** ADDR_W;

    localparam logic [1:0] INIT = 2'd0;
    localparam logic [1:0] IDLE = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;
    localparam logic [1:0] RESP = 2'd3;

    logic [1:0]        state;
    logic [3:0]        cnt;
    logic [ADDR_W-1:0] cap_addr;
    logic              cap_we;
    logic [DATA_W-1:0] cap_wdata;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              accept;
    logic              access;
    logic [ADDR_W-1:0] acc_addr;
    logic              acc_we;
    logic [DATA_W-1:0] acc_wdata;

    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == RESP);
    assign busy       = (state != IDLE);
    assign accept     = req_valid && req_ready;

    // A single-cycle build performs the access on the accepting edge straight
    // from the request bus; longer builds use the captured copy.
    always_comb begin
        access    = 1'b0;
        acc_addr  = cap_addr;
        acc_we    = cap_we;
        acc_wdata = cap_wdata;
        if (LATENCY == 1) begin
            access    = accept;
            acc_addr  = req_addr;
            acc_we    = req_we;
            acc_wdata = req_wdata;
        end else begin
            access = (state == WAIT) && (cnt == 4'd1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= INIT;
            cnt        <= '0;
            cap_addr   <= '0;
            cap_we     <= 1'b0;
            cap_wdata  <= '0;
            resp_rdata <= '0;
            resp_we    <= 1'b0;
        end else begin
            case (state)
                INIT: state <= IDLE;
                IDLE: begin
                    if (accept) begin
                        cap_addr  <= req_addr;
                        cap_we    <= req_we;
                        cap_wdata <= req_wdata;
                        if (LATENCY == 1) begin
                            state <= RESP;
                        end else begin
                            state <= WAIT;
                            cnt   <= 4'(LATENCY - 1);
                        end
                    end
                end
                WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) state <= RESP;
                end
                RESP: begin
                    if (resp_ready) state <= IDLE;
                end
                default: state <= INIT;
            endcase

            if (access) begin
                resp_rdata <= acc_we ? acc_wdata : mem[acc_addr];
                resp_we    <= acc_we;
            end
        end
    end

    // Array has no reset so its contents survive rst_n; a pending write is lost
    // because reset forces the FSM out of WAIT before its access edge.
    always_ff @(posedge clk) begin
        if (access && acc_we) mem[acc_addr] <= acc_wdata;
    end

endmodule

// File: tb/tb_ias_memory_responder.sv
// Self-checking bench for ias_memory_responder: one LATENCY=2 and one LATENCY=1
// instance, checked against a word-array reference model with directed and random traffic.
module tb_ias_memory_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]      rst_n      = 2'b00;
    logic [1:0]      req_valid  = 2'b00;
    logic [1:0]      req_we     = 2'b00;
    logic [1:0]      resp_ready = 2'b00;
    logic [1:0][7:0] req_addr   = '0;
    logic [1:0][7:0] req_wdata  = '0;
    logic [1:0]      req_ready, resp_valid, resp_we, busy;
    logic [1:0][7:0] resp_rdata;

    int total = 0;
    int bad   = 0;

    logic [7:0] ref_mem [2][256];
    bit         known   [2][256];

    ias_memory_responder #(.DATA_W(8), .ADDR_W(8), .LATENCY(2)) dut_l2 (
        .clk(clk), .rst_n(rst_n[0]),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
        .resp_rdata(resp_rdata[0]), .resp_we(resp_we[0]), .busy(busy[0])
    );

    ias_memory_responder #(.DATA_W(8), .ADDR_W(8), .LATENCY(1)) dut_l1 (
        .clk(clk), .rst_n(rst_n[1]),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
        .resp_rdata(resp_rdata[1]), .resp_we(resp_we[1]), .busy(busy[1])
    );

    function automatic int lat_of(int u);
        return (u == 0) ? 2 : 1;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(int u, string tag);
        chk({tag, "_req_ready"},  req_ready[u],  1'b0);
        chk({tag, "_busy"},       busy[u],       1'b1);
        chk({tag, "_resp_valid"}, resp_valid[u], 1'b0);
        chk({tag, "_resp_rdata"}, resp_rdata[u], 8'h00);
        chk({tag, "_resp_we"},    resp_we[u],    1'b0);
    endtask

    // Caller is positioned on a falling edge; reset is asserted immediately.
    task automatic do_reset(int u);
        rst_n[u]      = 1'b0;
        req_valid[u]  = 1'b0;
        resp_ready[u] = 1'b0;
        #1 chk_reset_vals(u, "rst_assert");
        repeat (3) @(negedge clk);
        chk_reset_vals(u, "rst_hold");
        rst_n[u] = 1'b1;
        #1;
        chk("init_req_ready", req_ready[u], 1'b0);
        chk("init_busy",      busy[u],      1'b1);
        @(negedge clk);
        chk("idle_req_ready",  req_ready[u],  1'b1);
        chk("idle_busy",       busy[u],       1'b0);
        chk("idle_resp_valid", resp_valid[u], 1'b0);
    endtask

    // resp_valid must be sampled high by edge N+LATENCY where N accepts the request.
    // rst_at >= 0 asserts reset on the falling edge rst_at cycles after acceptance.
    task automatic txn(int u, bit we, logic [7:0] addr, logic [7:0] wdata,
                       int stall, bit hold_req, int rst_at);
        int         lat   = lat_of(u);
        int         waitc = 0;
        bit         dchk  = we || known[u][addr];
        logic [7:0] exp   = we ? wdata : ref_mem[u][addr];
        @(negedge clk);
        while (!req_ready[u] && waitc < 20) begin
            @(negedge clk);
            waitc++;
        end
        chk("req_ready_before", req_ready[u], 1'b1);
        req_valid[u] = 1'b1;
        req_we[u]    = we;
        req_addr[u]  = addr;
        req_wdata[u] = wdata;
        @(negedge clk);
        if (!hold_req) req_valid[u] = 1'b0;
        req_we[u]    = 1'($urandom);
        req_addr[u]  = 8'($urandom);
        req_wdata[u] = 8'($urandom);
        for (int k = 0; k < lat; k++) begin
            if (k > 0) @(negedge clk);
            if (k < lat - 1) begin
                chk("wait_resp_valid", resp_valid[u], 1'b0);
                chk("wait_req_ready",  req_ready[u],  1'b0);
                chk("wait_busy",       busy[u],       1'b1);
                resp_ready[u] = 1'($urandom_range(0, 1));
            end else begin
                chk("resp_valid", resp_valid[u], 1'b1);
                chk("resp_req_ready", req_ready[u], 1'b0);
                chk("resp_we", resp_we[u], we);
                if (dchk) chk("resp_rdata", resp_rdata[u], exp);
                resp_ready[u] = 1'b0;
                if (we) begin
                    ref_mem[u][addr] = wdata;
                    known[u][addr]   = 1'b1;
                end
            end
            if (k == rst_at) begin
                do_reset(u);
                return;
            end
        end
        repeat (stall) begin
            @(negedge clk);
            chk("stall_resp_valid", resp_valid[u], 1'b1);
            chk("stall_req_ready",  req_ready[u],  1'b0);
            chk("stall_resp_we",    resp_we[u],    we);
            if (dchk) chk("stall_resp_rdata", resp_rdata[u], exp);
        end
        resp_ready[u] = 1'b1;
        @(negedge clk);
        chk("post_hs_resp_valid", resp_valid[u], 1'b0);
        chk("post_hs_req_ready",  req_ready[u],  1'b1);
        resp_ready[u] = 1'b0;
        req_valid[u]  = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired before end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        @(negedge clk);
        do_reset(0);
        do_reset(1);

        // write then read back
        txn(0, 1'b1, 8'h10, 8'h55, 0, 1'b0, -1);
        txn(0, 1'b0, 8'h10, 8'h00, 0, 1'b0, -1);

        // backpressure with a second request held pending
        txn(0, 1'b1, 8'h77, 8'h12, 0, 1'b0, -1);
        txn(0, 1'b0, 8'h10, 8'h00, 5, 1'b1, -1);
        txn(0, 1'b0, 8'h77, 8'h00, 0, 1'b0, -1);

        // boundary addresses
        txn(0, 1'b1, 8'hFF, 8'hAA, 0, 1'b0, -1);
        txn(0, 1'b1, 8'h00, 8'h01, 0, 1'b0, -1);
        txn(0, 1'b0, 8'hFF, 8'h00, 0, 1'b0, -1);
        txn(0, 1'b0, 8'h00, 8'h00, 0, 1'b0, -1);

        // reset in WAIT discards the write, reset in RESP keeps it
        txn(0, 1'b1, 8'h20, 8'h55, 0, 1'b0, -1);
        txn(0, 1'b1, 8'h20, 8'h33, 0, 1'b0, 0);
        txn(0, 1'b0, 8'h20, 8'h00, 0, 1'b0, -1);
        chk("rst_wait_discard", ref_mem[0][8'h20], 8'h55);
        txn(0, 1'b1, 8'h20, 8'h33, 0, 1'b0, 1);
        txn(0, 1'b0, 8'h20, 8'h00, 0, 1'b0, -1);
        txn(0, 1'b0, 8'hFF, 8'h00, 0, 1'b0, -1);

        for (int i = 0; i < 24; i++)
            txn(0, 1'($urandom), 8'($urandom_range(0, 15)), 8'($urandom),
                int'($urandom_range(0, 3)), 1'($urandom), -1);

        // single-cycle build
        txn(1, 1'b1, 8'h10, 8'h5A, 0, 1'b0, -1);
        txn(1, 1'b0, 8'h10, 8'h00, 2, 1'b0, -1);
        for (int i = 0; i < 12; i++)
            txn(1, 1'($urandom), 8'($urandom_range(0, 7)), 8'($urandom),
                int'($urandom_range(0, 2)), 1'b0, -1);
        txn(1, 1'b1, 8'h10, 8'hC3, 0, 1'b0, -1);

        // back-to-back reads with resp_ready held high: one accept every 2 edges
        @(negedge clk);
        acc = 0;
        resp_ready[1] = 1'b1;
        req_valid[1]  = 1'b1;
        req_we[1]     = 1'b0;
        req_addr[1]   = 8'h10;
        for (int i = 0; i < 10; i++) begin
            if (req_ready[1]) acc++;
            @(negedge clk);
            if (resp_valid[1]) chk("b2b_rdata", resp_rdata[1], ref_mem[1][8'h10]);
        end
        req_valid[1]  = 1'b0;
        resp_ready[1] = 1'b0;
        chk("b2b_accepts", acc, 5);
        chk("b2b_end_idle", req_ready[1], 1'b1);

        // reset mid-operation on the single-cycle build: RESP write stays committed
        txn(1, 1'b1, 8'h40, 8'h9E, 0, 1'b0, 0);
        txn(1, 1'b0, 8'h40, 8'h00, 0, 1'b0, -1);
        chk("l1_commit_model", ref_mem[1][8'h40], 8'h9E);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
